// File: rtl/jt89_pkg.sv
// Shared JT89 encodings: noise rate select, mode bit, default tap masks, attenuation table.
package jt89_pkg;

  typedef enum logic [1:0] {
    RATE0    = 2'd0,
    RATE1    = 2'd1,
    RATE2    = 2'd2,
    RATE_CH2 = 2'd3
  } rate_e;

  localparam int MODE_BIT = 2;

  localparam logic [15:0] TAPS_SMS = 16'h0009;
  localparam logic [14:0] TAPS_SN  = 15'h0003;
  localparam int          W_SN     = 15;

  // Roughly 2 dB per step; the last step is a hard mute.
  function automatic logic [8:0] att_lvl(input logic [3:0] v);
    logic [8:0] lvl;
    case (v)
      4'd0:    lvl = 9'd255;
      4'd1:    lvl = 9'd203;
      4'd2:    lvl = 9'd161;
      4'd3:    lvl = 9'd128;
      4'd4:    lvl = 9'd102;
      4'd5:    lvl = 9'd81;
      4'd6:    lvl = 9'd64;
      4'd7:    lvl = 9'd51;
      4'd8:    lvl = 9'd40;
      4'd9:    lvl = 9'd32;
      4'd10:   lvl = 9'd25;
      4'd11:   lvl = 9'd20;
      4'd12:   lvl = 9'd16;
      4'd13:   lvl = 9'd13;
      4'd14:   lvl = 9'd10;
      default: lvl = 9'd0;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/jt89_vol.sv
// Attenuator: registers a signed sample of the channel bit scaled by vol; one tick of latency.
// Free-running, no backpressure.
module jt89_vol
  import jt89_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_din,
  input  logic [3:0]        i_vol,
  output logic signed [9:0] o_snd
);

  logic signed [9:0] r_snd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_snd <= '0;
    end else if (i_clk_en) begin
      r_snd <= i_din ? signed'({1'b0, att_lvl(i_vol)}) : 10'sd0;
    end
  end

  assign o_snd = r_snd;

endmodule

// File: rtl/jt89_noisegen.sv
// Noise channel: prescaled or ch2-clocked Fibonacci LFSR; nbit one clk after the update tick,
// snd one tick after nbit. Free-running, no backpressure.
module jt89_noisegen
  import jt89_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = TAPS_SMS,
  parameter int           DIV0 = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              clr,
  input  logic [2:0]        ctrl3,
  input  logic [3:0]        vol,
  input  logic              ch2,
  output logic              nbit,
  output logic signed [9:0] snd
);

  localparam int           CW   = $clog2(4 * DIV0);
  localparam logic [W-1:0] SEED = {1'b1, {(W-1){1'b0}}};

  logic [CW-1:0] r_cnt;
  logic          r_ph;
  logic          r_last_ch2;
  logic [W-1:0]  r_shift;

  rate_e         w_rate;
  logic [CW-1:0] w_reload;
  logic          w_cnt_zero;
  logic          w_upd;
  logic          w_fb;

  assign w_rate     = rate_e'(ctrl3[1:0]);
  assign w_cnt_zero = (r_cnt == '0);

  // Rate 3 keeps the prescaler alive on the slowest reload so a switch back is glitch-free.
  always_comb begin
    w_reload = CW'(4 * DIV0 - 1);
    case (w_rate)
      RATE0:   w_reload = CW'(DIV0 - 1);
      RATE1:   w_reload = CW'(2 * DIV0 - 1);
      default: w_reload = CW'(4 * DIV0 - 1);
    endcase
  end

  assign w_upd = clk_en && ((w_rate == RATE_CH2) ? (ch2 && !r_last_ch2)
                                                 : (w_cnt_zero && !r_ph));

  assign w_fb = ctrl3[MODE_BIT] ? ^(r_shift & TAPS) : r_shift[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_ph       <= 1'b0;
      r_last_ch2 <= 1'b0;
      r_shift    <= SEED;
    end else begin
      if (clk_en) begin
        if (w_cnt_zero) begin
          r_cnt <= w_reload;
          r_ph  <= ~r_ph;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        r_last_ch2 <= ch2;
      end
      // A register write reseeds even when it lands on an update tick.
      if (clr) begin
        r_shift <= SEED;
      end else if (w_upd) begin
        r_shift <= (r_shift == '0) ? SEED : {w_fb, r_shift[W-1:1]};
      end
    end
  end

  assign nbit = r_shift[0];

  jt89_vol u_vol (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clk_en (clk_en),
    .i_din    (nbit),
    .i_vol    (vol),
    .o_snd    (snd)
  );

endmodule

// File: tb/tb_jt89_noisegen.sv
// Directed bench for jt89_noisegen: default instance plus a zero-tap instance for the lock-up guard.
module tb_jt89_noisegen;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clk_en = 1'b1;
  logic              clr = 1'b0;
  logic [2:0]        ctrl3 = 3'b100;
  logic [3:0]        vol = 4'd0;
  logic              ch2 = 1'b0;
  logic              nbit;
  logic signed [9:0] snd;

  logic [2:0]        ctrl3_2 = 3'b100;
  logic [3:0]        vol_2 = 4'd15;
  logic              nbit_2;
  logic signed [9:0] snd_2;

  int n_pass = 0;
  int n_tot  = 0;
  int n_high;

  always #5 clk = ~clk;

  jt89_noisegen dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (clr),
    .ctrl3  (ctrl3),
    .vol    (vol),
    .ch2    (ch2),
    .nbit   (nbit),
    .snd    (snd)
  );

  jt89_noisegen #(.W(16), .TAPS(16'h0000), .DIV0(16)) dut_lk (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clr    (clr),
    .ctrl3  (ctrl3_2),
    .vol    (vol_2),
    .ch2    (ch2),
    .nbit   (nbit_2),
    .snd    (snd_2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tot++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Rate 0 white: updates at ticks 0, 32, 64.
    ctrl3 = 3'b100;
    vol   = 4'd0;
    do_reset();
    chk("rst_shift", 32'(dut.r_shift), 32'h8000);
    chk("rst_cnt",   32'(dut.r_cnt),   32'd0);
    chk("rst_nbit",  32'(nbit),        32'd0);
    chk("rst_snd",   32'(snd),         32'd0);
    step(1);
    chk("r0_upd1",   32'(dut.r_shift), 32'h4000);
    chk("r0_cnt1",   32'(dut.r_cnt),   32'd15);
    step(31);
    chk("r0_hold",   32'(dut.r_shift), 32'h4000);
    step(1);
    chk("r0_upd2",   32'(dut.r_shift), 32'h2000);

    // Periodic: the seed bit walks down and wraps on the 16th update.
    ctrl3  = 3'b000;
    vol    = 4'd0;
    n_high = 0;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step(k == 1 ? 1 : (k == 16 ? 30 : 32));
      chk("per_shift", 32'(dut.r_shift), (k == 16) ? 32'h8000 : (32'h8000 >> k));
      if (nbit) n_high++;
      if (k == 15) begin
        chk("per_snd_lag", 32'(snd), 32'd0);
        step(1);
        chk("per_snd_v0", 32'(snd), 32'd255);
        vol = 4'd4;
        step(1);
        chk("per_snd_v4", 32'(snd), 32'd102);
      end
    end
    chk("per_nbit_cnt", 32'(n_high), 32'd1);
    chk("per_snd_hold", 32'(snd), 32'd102);
    // Asynchronous reset between edges.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_shift", 32'(dut.r_shift), 32'h8000);
    chk("arst_cnt",   32'(dut.r_cnt),   32'd0);
    chk("arst_nbit",  32'(nbit),        32'd0);
    chk("arst_snd",   32'(snd),         32'd0);
    #2;
    rst = 1'b0;

    // White tap check.
    ctrl3 = 3'b100;
    vol   = 4'd0;
    do_reset();
    step(1);
    step(32 * 11);
    chk("wht_12", 32'(dut.r_shift), 32'h0008);
    step(32);
    chk("wht_13", 32'(dut.r_shift), 32'h8004);

    // Rate 3: ch2 rising edges only.
    ctrl3 = 3'b111;
    ch2   = 1'b0;
    do_reset();
    step(3);
    chk("ch2_idle_shift", 32'(dut.r_shift), 32'h8000);
    chk("ch2_idle_cnt",   32'(dut.r_cnt),   32'd61);
    for (int p = 0; p < 5; p++) begin
      ch2 = 1'b1;
      step(5);
      chk("ch2_rise", 32'(dut.r_shift), 32'h8000 >> (p + 1));
      ch2 = 1'b0;
      step(5);
      chk("ch2_fall", 32'(dut.r_shift), 32'h8000 >> (p + 1));
    end
    step(80);
    chk("ch2_cnt_wrap", 32'(dut.r_shift), 32'h0400);

    // Clear with and without clk_en.
    ctrl3 = 3'b100;
    do_reset();
    step(5);
    chk("clr_pre", 32'(dut.r_shift), 32'h4000);
    clk_en = 1'b0;
    clr    = 1'b1;
    step(1);
    clr    = 1'b0;
    chk("clr_noen_shift", 32'(dut.r_shift), 32'h8000);
    chk("clr_noen_cnt",   32'(dut.r_cnt),   32'd11);
    step(2);
    chk("noen_cnt_hold",  32'(dut.r_cnt),   32'd11);
    clk_en = 1'b1;
    step(27);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_on_upd_shift", 32'(dut.r_shift), 32'h8000);
    chk("clr_on_upd_cnt",   32'(dut.r_cnt),   32'd15);
    step(32);
    chk("clr_next_upd", 32'(dut.r_shift), 32'h4000);

    // Lock-up guard on the zero-tap instance.
    ctrl3   = 3'b100;
    ctrl3_2 = 3'b100;
    vol_2   = 4'd15;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(k == 1 ? 1 : 32);
      chk("lk_shift", 32'(dut_lk.r_shift), (k == 17) ? 32'h8000 : (32'h8000 >> k));
      chk("lk_snd", 32'(snd_2), 32'd0);
      if (k == 15) chk("lk_nbit", 32'(nbit_2), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
